// File: rtl/instr_encoder_loader_pkg.sv
// Shared ISA definitions for the instruction encoder/loader: word field layout,
// opcode map, opcode legality, word packing and the loader FSM state type.
// No ports; imported by the encoder/loader RTL.
package instr_encoder_loader_pkg;

   // Instruction word layout: opcode[15:12], reg[11:8], imm[7:0]
   localparam int ISA_W   = 16;
   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 8;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   // Opcode map; 0xB and 0xE are unassigned and therefore illegal
   localparam logic [3:0] OP_MOVI    = 4'h0;
   localparam logic [3:0] OP_ADD     = 4'h1;
   localparam logic [3:0] OP_SUB     = 4'h2;
   localparam logic [3:0] OP_AND     = 4'h3;
   localparam logic [3:0] OP_OR      = 4'h4;
   localparam logic [3:0] OP_XOR     = 4'h5;
   localparam logic [3:0] OP_SHL     = 4'h6;
   localparam logic [3:0] OP_SHR     = 4'h7;
   localparam logic [3:0] OP_JMP     = 4'h8;
   localparam logic [3:0] OP_JZ      = 4'h9;
   localparam logic [3:0] OP_JNZ     = 4'hA;
   localparam logic [3:0] OP_STORE   = 4'hC;
   localparam logic [3:0] OP_LOAD    = 4'hD;
   localparam logic [3:0] OP_STORE_V = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic is_legal_opcode(input logic [3:0] op);
      logic legal;
      case (op)
         OP_MOVI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR,
         OP_JMP, OP_JZ, OP_JNZ, OP_STORE, OP_LOAD, OP_STORE_V: legal = 1'b1;
         default:                                              legal = 1'b0;
      endcase
      return legal;
   endfunction

   function automatic logic [ISA_W-1:0] pack_word(input logic [3:0] op,
                                                  input logic [3:0] rd,
                                                  input logic [7:0] imm);
      logic [ISA_W-1:0] w;
      w                  = '0;
      w[OPC_MSB:OPC_LSB] = op;
      w[RD_MSB:RD_LSB]   = rd;
      w[IMM_MSB:IMM_LSB] = imm;
      return w;
   endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Bus bundle for the encoder/loader: field-tuple input stream (valid/ready)
// and the instruction-memory write port (we/ready).
// slave = loader side, master = host/memory side.
interface instr_encoder_loader_if #(
   parameter int N  = 16,
   parameter int AW = 8
);
   // field tuple stream
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    in_opcode;
   logic [3:0]    in_rd;
   logic [7:0]    in_imm;
   logic          in_last;
   // instruction memory write port
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [N-1:0]  mem_wdata;
   logic          mem_ready;

   modport slave (
      input  in_valid, in_opcode, in_rd, in_imm, in_last, mem_ready,
      output in_ready, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output in_valid, in_opcode, in_rd, in_imm, in_last, mem_ready,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/instr_encoder_loader_sync_fifo.sv
// Small synchronous FIFO holding encoded words between encoder and memory port.
// Latency: a pushed word is visible on head_o the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on full_o/empty_o.
// Ports: clk, rst (async active-high), push_i/push_dat_i, pop_i, full_o, empty_o, head_o.
module instr_encoder_loader_sync_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] push_dat_i,
   input  logic         pop_i,
   output logic         full_o,
   output logic         empty_o,
   output logic [W-1:0] head_o
);
   localparam int PW = $clog2(DEPTH);

   // pointers carry one extra wrap bit to tell full from empty
   logic [PW:0]  wr_ptr_q;
   logic [PW:0]  rd_ptr_q;
   logic [W-1:0] mem_q [DEPTH];
   logic         do_push;
   logic         do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                    (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign head_o  = mem_q[rd_ptr_q[PW-1:0]];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // storage needs no reset: it is only read through head_o when non-empty
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_dat_i;
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes (opcode, reg, imm) tuples into 16-bit words, drops illegal opcodes,
// and writes the words sequentially into instruction memory from base_addr.
// Latency: word accepted in cycle t is on mem_wdata at t+1 at the earliest.
// Backpressure: in_ready low outside LOAD or when the FIFO is full; mem_we holds addr/data until mem_ready.
// Ports: clk, rst (async active-high); bus (slave: tuple stream + memory write port);
//        start/base_addr session control; busy, done, words_written, illegal_err, overflow_err status.
module instr_encoder_loader
   import instr_encoder_loader_pkg::*;
#(
   parameter int N     = 16,
   parameter int AW    = 8,
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   instr_encoder_loader_if.slave bus,
   input  logic                  start,
   input  logic [AW-1:0]         base_addr,
   output logic                  busy,
   output logic                  done,
   output logic [AW:0]           words_written,
   output logic                  illegal_err,
   output logic                  overflow_err
);
   localparam logic [AW:0] WW_MAX = {1'b1, {AW{1'b0}}};

   state_t        state_q;
   logic [AW-1:0] wptr_q;
   logic [AW:0]   ww_q;
   logic          ill_q;
   logic          ovf_q;
   logic          last_seen_q;
   logic          addr_full_q;
   logic          busy_q;
   logic          done_q;

   logic          fifo_full;
   logic          fifo_empty;
   logic [N-1:0]  fifo_head;
   logic          active;
   logic          in_ready_w;
   logic          hs;
   logic          legal;
   logic          push;
   logic          mem_we_w;
   logic          commit;
   logic          drop;
   logic          pop;

   assign active     = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
   // in_ready depends only on registered state so a same-cycle pop never raises it
   assign in_ready_w = (state_q == ST_LOAD) && !fifo_full;
   assign hs         = bus.in_valid && in_ready_w;
   assign legal      = is_legal_opcode(bus.in_opcode);
   assign push       = hs && legal;

   assign mem_we_w   = !fifo_empty && active && !addr_full_q;
   assign commit     = mem_we_w && bus.mem_ready;
   // once the top address has been written, remaining words drain without a write
   assign drop       = !fifo_empty && active && addr_full_q;
   assign pop        = commit || drop;

   instr_encoder_loader_sync_fifo #(
      .W     (N),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (push),
      .push_dat_i (pack_word(bus.in_opcode, bus.in_rd, bus.in_imm)),
      .pop_i      (pop),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .head_o     (fifo_head)
   );

   assign bus.in_ready  = in_ready_w;
   assign bus.mem_we    = mem_we_w;
   assign bus.mem_addr  = wptr_q;
   assign bus.mem_wdata = fifo_empty ? '0 : fifo_head;

   assign busy          = busy_q;
   assign done          = done_q;
   assign words_written = ww_q;
   assign illegal_err   = ill_q;
   assign overflow_err  = ovf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wptr_q      <= '0;
         ww_q        <= '0;
         ill_q       <= 1'b0;
         ovf_q       <= 1'b0;
         last_seen_q <= 1'b0;
         addr_full_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q     <= ST_LOAD;
                  wptr_q      <= base_addr;
                  ww_q        <= '0;
                  ill_q       <= 1'b0;
                  ovf_q       <= 1'b0;
                  last_seen_q <= 1'b0;
                  addr_full_q <= 1'b0;
                  busy_q      <= 1'b1;
               end
            end
            ST_LOAD: begin
               // last closes the session even when its own tuple is dropped as illegal
               if (hs && bus.in_last) begin
                  last_seen_q <= 1'b1;
                  state_q     <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               if (fifo_empty && last_seen_q) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
            end
            default: state_q <= ST_IDLE;
         endcase

         if (hs && !legal) ill_q <= 1'b1;

         if (commit) begin
            // pointer parks at the top address rather than wrapping
            if (wptr_q == {AW{1'b1}}) addr_full_q <= 1'b1;
            else                      wptr_q      <= wptr_q + 1'b1;
            if (ww_q != WW_MAX)       ww_q        <= ww_q + 1'b1;
         end

         if (drop) ovf_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a queue-based model predicts every
// memory write from session base + count of legal tuples; a negedge monitor
// compares each write and write-hold cycle, tests pin the model with literals.
module tb_instr_encoder_loader;
   localparam int AW = 8;
   localparam int N  = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic          busy;
   logic          done;
   logic [AW:0]   words_written;
   logic          illegal_err;
   logic          overflow_err;

   always #5 clk = ~clk;

   instr_encoder_loader_if #(.N(N), .AW(AW)) bus ();

   instr_encoder_loader #(.N(N), .AW(AW), .DEPTH(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .start         (start),
      .base_addr     (base_addr),
      .busy          (busy),
      .done          (done),
      .words_written (words_written),
      .illegal_err   (illegal_err),
      .overflow_err  (overflow_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   typedef struct {
      logic [7:0]  addr;
      logic [15:0] data;
   } wr_t;

   wr_t         exp_q[$];
   logic [7:0]  log_addr[$];
   logic [15:0] log_data[$];
   int          m_base;
   int          m_k;
   int          m_ww;
   bit          m_ill;
   bit          m_ovf;
   int          done_cnt = 0;
   bit          prev_stall = 0;
   logic [7:0]  prev_addr;
   logic [15:0] prev_data;

   function automatic bit tb_illegal(input logic [3:0] op);
      return (op == 4'hB) || (op == 4'hE);
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            check("hold_we",   bus.mem_we,    1);
            check("hold_addr", bus.mem_addr,  prev_addr);
            check("hold_data", bus.mem_wdata, prev_data);
         end
         if (bus.mem_we) begin
            if (exp_q.size() == 0) begin
               check("unexpected_we", bus.mem_we, 0);
            end else begin
               check("wr_addr", bus.mem_addr,  exp_q[0].addr);
               check("wr_data", bus.mem_wdata, exp_q[0].data);
               if (bus.mem_ready) begin
                  log_addr.push_back(bus.mem_addr);
                  log_data.push_back(bus.mem_wdata);
                  void'(exp_q.pop_front());
               end
            end
         end
         prev_stall = bus.mem_we && !bus.mem_ready;
         prev_addr  = bus.mem_addr;
         prev_data  = bus.mem_wdata;
         if (bus.in_valid && bus.in_ready) begin
            if (tb_illegal(bus.in_opcode)) begin
               m_ill = 1;
            end else begin
               if (m_base + m_k <= 255) begin
                  exp_q.push_back('{addr: 8'(m_base + m_k),
                                    data: {bus.in_opcode, bus.in_rd, bus.in_imm}});
                  m_ww++;
               end else begin
                  m_ovf = 1;
               end
               m_k++;
            end
         end
         if (done) done_cnt++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [7:0] b);
      m_base = int'(b);
      m_k    = 0;
      m_ww   = 0;
      m_ill  = 0;
      m_ovf  = 0;
      log_addr.delete();
      log_data.delete();
      start     = 1'b1;
      base_addr = b;
      tick();
      start     = 1'b0;
   endtask

   task automatic send(input logic [3:0] op, input logic [3:0] rd,
                       input logic [7:0] imm, input logic last);
      bit ok = 0;
      bus.in_valid  = 1'b1;
      bus.in_opcode = op;
      bus.in_rd     = rd;
      bus.in_imm    = imm;
      bus.in_last   = last;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: tuple op=0x%0h not accepted within 200 cycles", op);
      end
   endtask

   task automatic wait_done(input string name, input int bound);
      bit ok = 0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: done not seen within %0d cycles", name, bound);
      end else begin
         @(negedge clk);
         check({name, "_one_cycle"}, done, 0);
      end
      tick();
   endtask

   task automatic check_session(input string name, input int ww, input bit ill, input bit ovf);
      check({name, "_ww_model"},  words_written, m_ww);
      check({name, "_ww"},        words_written, ww);
      check({name, "_ill_model"}, illegal_err,   m_ill);
      check({name, "_ill"},       illegal_err,   ill);
      check({name, "_ovf_model"}, overflow_err,  m_ovf);
      check({name, "_ovf"},       overflow_err,  ovf);
      check({name, "_pending"},   exp_q.size(),  0);
      check({name, "_busy"},      busy,          0);
      check({name, "_nwrites"},   log_data.size(), ww);
   endtask

   // ---------------- tests ----------------
   int dc;

   initial begin
      rst           = 1'b1;
      start         = 1'b0;
      base_addr     = '0;
      bus.in_valid  = 1'b0;
      bus.in_opcode = '0;
      bus.in_rd     = '0;
      bus.in_imm    = '0;
      bus.in_last   = 1'b0;
      bus.mem_ready = 1'b0;
      #2;
      check("rst_in_ready", bus.in_ready,  0);
      check("rst_mem_we",   bus.mem_we,    0);
      check("rst_addr",     bus.mem_addr,  0);
      check("rst_wdata",    bus.mem_wdata, 0);
      check("rst_busy",     busy,          0);
      check("rst_done",     done,          0);
      check("rst_ww",       words_written, 0);
      check("rst_ill",      illegal_err,   0);
      check("rst_ovf",      overflow_err,  0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // T1: single LOAD word
      bus.mem_ready = 1'b1;
      do_start(8'h10);
      check("t1_busy", busy, 1);
      send(4'hD, 4'h5, 8'h3C, 1'b1);
      wait_done("t1_done", 10);
      check_session("t1", 1, 0, 0);
      if (log_data.size() == 1) begin
         check("t1_addr_lit", log_addr[0], 8'h10);
         check("t1_data_lit", log_data[0], 16'hD53C);
      end

      // T2: fill FIFO under memory stall, ignored start, then drain
      bus.mem_ready = 1'b0;
      do_start(8'h10);
      send(4'h2, 4'h1, 8'h11, 1'b0);
      send(4'h3, 4'h2, 8'h22, 1'b0);
      send(4'h4, 4'h3, 8'h33, 1'b0);
      send(4'h5, 4'h4, 8'h44, 1'b0);
      check("t2_in_ready_full", bus.in_ready, 0);
      start     = 1'b1;
      base_addr = 8'h80;
      tick();
      start     = 1'b0;
      tick();
      check("t2_in_ready_still", bus.in_ready, 0);
      check("t2_we_held",        bus.mem_we,    1);
      check("t2_addr_held",      bus.mem_addr,  8'h10);
      check("t2_data_held",      bus.mem_wdata, 16'h2111);
      bus.mem_ready = 1'b1;
      send(4'hC, 4'h5, 8'h55, 1'b1);
      wait_done("t2_done", 20);
      check_session("t2", 5, 0, 0);
      if (log_addr.size() == 5) begin
         for (int i = 0; i < 5; i++) check("t2_addr_seq", log_addr[i], 8'h10 + i);
         check("t2_data_last", log_data[4], 16'hC555);
      end

      // T3: illegal opcode in the middle of a session
      do_start(8'h20);
      send(4'h1, 4'h2, 8'h03, 1'b0);
      send(4'hB, 4'h1, 8'hFF, 1'b0);
      send(4'h8, 4'h0, 8'h40, 1'b1);
      wait_done("t3_done", 20);
      check_session("t3", 2, 1, 0);
      if (log_data.size() == 2) begin
         check("t3_d0", log_data[0], 16'h1203);
         check("t3_d1", log_data[1], 16'h8040);
         check("t3_a1", log_addr[1], 8'h21);
      end

      // T4: top-of-memory overflow
      do_start(8'hFE);
      send(4'h6, 4'h1, 8'h01, 1'b0);
      send(4'h7, 4'h2, 8'h02, 1'b0);
      send(4'h9, 4'h3, 8'h03, 1'b1);
      wait_done("t4_done", 20);
      check_session("t4", 2, 0, 1);
      if (log_addr.size() == 2) begin
         check("t4_a0", log_addr[0], 8'hFE);
         check("t4_a1", log_addr[1], 8'hFF);
      end

      // T5: lone illegal tuple carrying last
      do_start(8'h30);
      send(4'hE, 4'h0, 8'h00, 1'b1);
      wait_done("t5_done", 3);
      check_session("t5", 0, 1, 0);

      // T6: asynchronous reset mid-session, then a clean session
      bus.mem_ready = 1'b0;
      do_start(8'h40);
      send(4'hA, 4'h1, 8'h11, 1'b0);
      send(4'hB, 4'h0, 8'h00, 1'b0);
      send(4'h0, 4'h2, 8'h22, 1'b0);
      tick();
      check("t6_pre_ill",  illegal_err,  1);
      check("t6_pre_we",   bus.mem_we,   1);
      check("t6_pre_addr", bus.mem_addr, 8'h40);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("t6_rst_we",       bus.mem_we,    0);
      check("t6_rst_addr",     bus.mem_addr,  0);
      check("t6_rst_wdata",    bus.mem_wdata, 0);
      check("t6_rst_in_ready", bus.in_ready,  0);
      check("t6_rst_busy",     busy,          0);
      check("t6_rst_ill",      illegal_err,   0);
      check("t6_rst_done",     done,          0);
      dc = done_cnt;
      bus.mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (6) tick();
      check("t6_no_done", done_cnt,   dc);
      check("t6_idle_we", bus.mem_we, 0);
      check("t6_idle_ww", words_written, 0);
      do_start(8'h50);
      send(4'h3, 4'h3, 8'h33, 1'b1);
      wait_done("t6_done", 10);
      check_session("t6", 1, 0, 0);
      if (log_addr.size() == 1) check("t6_addr_lit", log_addr[0], 8'h50);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
